// File: rtl/fp16_pkg.sv
// Shared binary16 constants, FSM state type and field-unpack helper for the
// half-precision multiplier.
package fp16_pkg;

   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;
   localparam int BIAS   = 15;

   localparam logic [15:0] QNAN = 16'h7E00;
   localparam logic [15:0] INF  = 16'h7C00;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      MULT    = 2'd1,
      NORM    = 2'd2,
      ROUND   = 2'd3
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   function automatic fp16_t fp16_unpack(input logic [15:0] x);
      fp16_t f;
      f.sign = x[15];
      f.exp  = x[14:10];
      f.frac = x[9:0];
      return f;
   endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even, range check and special-case packing
// of a normalised binary16 product.
module fp16_round_pack
   import fp16_pkg::*;
(
   input  logic        i_sign,
   input  logic [6:0]  i_exp,
   input  logic [9:0]  i_frac,
   input  logic        i_guard,
   input  logic        i_round,
   input  logic        i_sticky,
   input  logic        i_nan,
   input  logic        i_inf,
   input  logic        i_zero,
   output logic [15:0] o_result
);

   logic               w_round_up;
   logic [10:0]        w_sum;
   logic signed [6:0]  w_exp_adj;

   assign w_round_up = i_guard & (i_round | i_sticky | i_frac[0]);
   assign w_sum      = {1'b0, i_frac} + {10'd0, w_round_up};
   // A carry out of the fraction leaves it all-zero; only the exponent moves.
   assign w_exp_adj  = i_exp + {6'd0, w_sum[10]};

   always_comb begin
      o_result = {i_sign, 15'd0};
      if (i_nan || (i_inf && i_zero)) begin
         o_result = QNAN;
      end else if (i_inf) begin
         o_result = {i_sign, INF[14:0]};
      end else if (i_zero) begin
         o_result = {i_sign, 15'd0};
      end else if (w_exp_adj >= 7'sd31) begin
         o_result = {i_sign, INF[14:0]};
      end else if (w_exp_adj <= 7'sd0) begin
         o_result = {i_sign, 15'd0};
      end else begin
         o_result = {i_sign, w_exp_adj[4:0], w_sum[9:0]};
      end
   end

endmodule

// File: rtl/my_float_mult.sv
// Free-running binary16 multiplier: CAPTURE -> MULT -> NORM -> ROUND, one
// result with a single-cycle done pulse every four clocks.
module my_float_mult
   import fp16_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic            clk_44,
   input  logic            reset_44,
   input  logic [SIZE-1:0] multIn1_44,
   input  logic [SIZE-1:0] multIn2_44,
   output logic [SIZE-1:0] multOut_44,
   output logic            d_o_44
);

   state_t      r_state;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        r_sign;
   logic [6:0]  r_exp;
   logic [21:0] r_prod;
   logic        r_nan;
   logic        r_inf;
   logic        r_zero;
   logic [9:0]  r_frac;
   logic        r_guard;
   logic        r_round;
   logic        r_sticky;
   logic [15:0] r_out;
   logic        r_done;

   fp16_t       w_ua;
   fp16_t       w_ub;
   logic        w_a_zero, w_b_zero;
   logic        w_a_inf,  w_b_inf;
   logic        w_a_nan,  w_b_nan;
   logic [21:0] w_prod;
   logic [15:0] w_result;

   assign w_ua = fp16_unpack(r_a);
   assign w_ub = fp16_unpack(r_b);

   // Exponent field 0 covers both true zero and flushed subnormals.
   assign w_a_zero = (w_ua.exp == 5'd0);
   assign w_b_zero = (w_ub.exp == 5'd0);
   assign w_a_inf  = (w_ua.exp == 5'd31) && (w_ua.frac == 10'd0);
   assign w_b_inf  = (w_ub.exp == 5'd31) && (w_ub.frac == 10'd0);
   assign w_a_nan  = (w_ua.exp == 5'd31) && (w_ua.frac != 10'd0);
   assign w_b_nan  = (w_ub.exp == 5'd31) && (w_ub.frac != 10'd0);

   assign w_prod = {11'd0, 1'b1, w_ua.frac} * {11'd0, 1'b1, w_ub.frac};

   fp16_round_pack u_round_pack (
      .i_sign   (r_sign),
      .i_exp    (r_exp),
      .i_frac   (r_frac),
      .i_guard  (r_guard),
      .i_round  (r_round),
      .i_sticky (r_sticky),
      .i_nan    (r_nan),
      .i_inf    (r_inf),
      .i_zero   (r_zero),
      .o_result (w_result)
   );

   always_ff @(posedge clk_44 or negedge reset_44) begin
      if (!reset_44) begin
         r_state  <= CAPTURE;
         r_a      <= 16'd0;
         r_b      <= 16'd0;
         r_sign   <= 1'b0;
         r_exp    <= 7'd0;
         r_prod   <= 22'd0;
         r_nan    <= 1'b0;
         r_inf    <= 1'b0;
         r_zero   <= 1'b0;
         r_frac   <= 10'd0;
         r_guard  <= 1'b0;
         r_round  <= 1'b0;
         r_sticky <= 1'b0;
         r_out    <= 16'd0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            CAPTURE: begin
               r_a     <= multIn1_44[15:0];
               r_b     <= multIn2_44[15:0];
               r_done  <= 1'b0;
               r_state <= MULT;
            end
            MULT: begin
               r_sign  <= w_ua.sign ^ w_ub.sign;
               r_exp   <= {2'd0, w_ua.exp} + {2'd0, w_ub.exp} - 7'(BIAS);
               r_prod  <= w_prod;
               r_nan   <= w_a_nan | w_b_nan;
               r_inf   <= w_a_inf | w_b_inf;
               r_zero  <= w_a_zero | w_b_zero;
               r_state <= NORM;
            end
            NORM: begin
               // Significand product lies in [1,4); bit21 means [2,4).
               if (r_prod[21]) begin
                  r_exp    <= r_exp + 7'd1;
                  r_frac   <= r_prod[20:11];
                  r_guard  <= r_prod[10];
                  r_round  <= r_prod[9];
                  r_sticky <= |r_prod[8:0];
               end else begin
                  r_frac   <= r_prod[19:10];
                  r_guard  <= r_prod[9];
                  r_round  <= r_prod[8];
                  r_sticky <= |r_prod[7:0];
               end
               r_state <= ROUND;
            end
            ROUND: begin
               r_out   <= w_result;
               r_done  <= 1'b1;
               r_state <= CAPTURE;
            end
            default: r_state <= CAPTURE;
         endcase
      end
   end

   assign multOut_44 = r_out;
   assign d_o_44     = r_done;

endmodule

// File: tb/tb_my_float_mult.sv
// Self-checking bench for my_float_mult: directed vectors, timing/reset cases
// and randomized operands against a real-arithmetic reference model.
module tb_my_float_mult;

   logic        clk_44 = 1'b0;
   logic        reset_44 = 1'b0;
   logic [15:0] multIn1_44 = 16'd0;
   logic [15:0] multIn2_44 = 16'd0;
   logic [15:0] multOut_44;
   logic        d_o_44;

   int n_checks = 0;
   int n_fail   = 0;

   my_float_mult #(.SIZE(16)) dut (
      .clk_44     (clk_44),
      .reset_44   (reset_44),
      .multIn1_44 (multIn1_44),
      .multIn2_44 (multIn2_44),
      .multOut_44 (multOut_44),
      .d_o_44     (d_o_44)
   );

   initial forever #5 clk_44 = ~clk_44;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: exact real product, then round to an 11-bit significand.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic s;
      bit   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      real  p, m, rem;
      int   e, mi, be;
      logic [15:0] res;
      s      = a[15] ^ b[15];
      a_zero = (a[14:10] == 5'd0);
      b_zero = (b[14:10] == 5'd0);
      a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
      b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
      a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
      b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
      if (a_nan || b_nan) return 16'h7E00;
      if ((a_inf || b_inf) && (a_zero || b_zero)) return 16'h7E00;
      if (a_inf || b_inf) return {s, 15'h7C00};
      if (a_zero || b_zero) return {s, 15'h0000};
      p = (1.0 + real'(int'(a[9:0])) / 1024.0) * pow2(int'(a[14:10]) - 15)
        * (1.0 + real'(int'(b[9:0])) / 1024.0) * pow2(int'(b[14:10]) - 15);
      e = 0;
      while (p >= pow2(e + 1)) e++;
      while (p < pow2(e)) e--;
      m   = p / pow2(e) * 1024.0;
      mi  = $rtoi(m);
      rem = m - real'(mi);
      if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
      if (mi == 2048) begin
         mi = 1024;
         e++;
      end
      be = e + 15;
      if (be >= 31) return {s, 15'h7C00};
      if (be <= 0)  return {s, 15'h0000};
      res = {s, be[4:0], 10'(mi - 1024)};
      return res;
   endfunction

   // Counts falling edges until done is seen; a healthy DUT needs at most 4.
   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk_44);
         cycles++;
      end while (!d_o_44 && cycles < 8);
   endtask

   function automatic logic [15:0] rand_operand();
      logic [15:0] v;
      int sel;
      v   = 16'($urandom);
      sel = $urandom_range(0, 11);
      if (sel == 0)      v[14:10] = 5'd0;
      else if (sel == 1) v[14:10] = 5'd31;
      else if (sel == 2) v[14:0]  = 15'h7C00;
      else if (sel < 8)  v[14:10] = 5'($urandom_range(9, 21));
      else               v[14:10] = 5'($urandom_range(1, 30));
      return v;
   endfunction

   localparam int N_DIR = 14;
   logic [15:0] dir_a [N_DIR] = '{16'h2E66, 16'hB4CD, 16'h4E46, 16'hC0E6, 16'h3C01, 16'h3C00, 16'h3BFF,
                                  16'h7BFF, 16'h0400, 16'h8400, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0001};
   logic [15:0] dir_b [N_DIR] = '{16'hB800, 16'h3A66, 16'h4300, 16'hC491, 16'h3C01, 16'h3C01, 16'h3C01,
                                  16'h4000, 16'h0400, 16'h0400, 16'h0000, 16'h3C00, 16'h4000, 16'h3C00};
   logic [15:0] dir_y [N_DIR] = '{16'hAA66, 16'hB3AE, 16'h557D, 16'h4998, 16'h3C02, 16'h3C01, 16'h3C00,
                                  16'h7C00, 16'h0000, 16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000};

   initial begin
      int cyc;
      logic [15:0] a, b, expv;

      reset_44   = 1'b0;
      multIn1_44 = dir_a[0];
      multIn2_44 = dir_b[0];
      repeat (2) @(negedge clk_44);
      check_eq("rst_out", multOut_44, 16'h0000);
      check_eq("rst_done", {15'd0, d_o_44}, 16'h0000);
      reset_44 = 1'b1;

      for (int i = 0; i < N_DIR; i++) begin
         wait_done(cyc);
         check_eq("dir_gap", 16'(cyc), 16'd4);
         check_eq("dir_out", multOut_44, dir_y[i]);
         $display("txn dir %0d: %h * %h -> %h (want %h)", i, dir_a[i], dir_b[i], multOut_44, dir_y[i]);
         if (i + 1 < N_DIR) begin
            multIn1_44 = dir_a[i + 1];
            multIn2_44 = dir_b[i + 1];
         end
      end

      // Operands changed during MULT must not affect the result in flight.
      multIn1_44 = 16'h3C01;
      multIn2_44 = 16'h3C01;
      @(negedge clk_44);
      multIn1_44 = 16'h4000;
      multIn2_44 = 16'h4000;
      wait_done(cyc);
      check_eq("late_gap", 16'(cyc + 1), 16'd4);
      check_eq("late_old", multOut_44, 16'h3C02);
      $display("txn late: in-flight 3C01 * 3C01 -> %h", multOut_44);
      wait_done(cyc);
      check_eq("late_gap2", 16'(cyc), 16'd4);
      check_eq("late_new", multOut_44, 16'h4400);
      $display("txn late: next 4000 * 4000 -> %h", multOut_44);

      // Asynchronous reset mid-operation discards the in-flight product.
      multIn1_44 = 16'h4E46;
      multIn2_44 = 16'h4300;
      repeat (2) @(negedge clk_44);
      multIn1_44 = 16'hC0E6;
      multIn2_44 = 16'hC491;
      reset_44 = 1'b0;
      #1;
      check_eq("mid_rst_out", multOut_44, 16'h0000);
      check_eq("mid_rst_done", {15'd0, d_o_44}, 16'h0000);
      reset_44 = 1'b1;
      wait_done(cyc);
      check_eq("post_rst_gap", 16'(cyc), 16'd4);
      check_eq("post_rst_out", multOut_44, 16'h4998);
      $display("txn reset: restart C0E6 * C491 -> %h", multOut_44);

      a = rand_operand();
      b = rand_operand();
      multIn1_44 = a;
      multIn2_44 = b;
      wait_done(cyc);
      for (int i = 0; i < 150; i++) begin
         wait_done(cyc);
         expv = ref_mul(a, b);
         check_eq("rnd_gap", 16'(cyc), 16'd4);
         check_eq("rnd_out", multOut_44, expv);
         $display("txn rnd %0d: %h * %h -> %h (want %h)", i, a, b, multOut_44, expv);
         a = rand_operand();
         b = rand_operand();
         multIn1_44 = a;
         multIn2_44 = b;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
